// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one memory request at a time, holds the returned word
// for decode, and redirects the PC on handoff. A misaligned target stops fetch for good.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branchTaken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm32,
  input  logic [31:0] rs1Data,
  output logic        halt
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] next_pc;

  always_comb begin
    if (jalr) begin
      next_pc = (rs1Data + imm32) & 32'hFFFF_FFFE;
    end else if (jal || branchTaken) begin
      next_pc = pc_q + imm32;
    end else begin
      next_pc = pc_q + 32'd4;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (inst_ready) begin
          // Halfword-misaligned target: keep the faulting pc visible and stop.
          if (next_pc[1]) begin
            state_d = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Request is gated by reset since the state register already sits in S_REQ while held.
  assign imem_req   = rst && (state_q == S_REQ);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = (state_q == S_OUT);
  assign halt       = (state_q == S_HALT);
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + 32'd4;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized memory/backpressure/redirect
// traffic, checked against a transaction-level model of the fetch stage.
module tb_inst_fetch;

  localparam logic [31:0] RstPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branchTaken;
  logic        jal;
  logic        jalr;
  logic [31:0] imm32;
  logic [31:0] rs1Data;
  logic        halt;

  inst_fetch #(.RESET_PC(RstPc)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .branchTaken (branchTaken),
    .jal         (jal),
    .jalr        (jalr),
    .imm32       (imm32),
    .rs1Data     (rs1Data),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: which phase the current fetch is in, expressed as transaction flags.
  logic [31:0] m_pc, m_inst;
  bit          m_halt, m_pend, m_have;
  int unsigned m_dly;
  int          cyc, handoffs, last_ho, ho_gap;

  int unsigned k_gnt_pct, k_dly_max, k_ready_pct;
  bit          k_redir, k_spur, k_mis;

  task automatic check_outputs();
    check_eq("halt", 32'(halt), 32'(m_halt));
    check_eq("pc", pc, m_pc);
    check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("inst_valid", 32'(inst_valid), 32'(!m_halt && m_have));
    check_eq("imem_req", 32'(imem_req), 32'(!m_halt && !m_pend && !m_have));
    if (m_have && !m_halt) check_eq("inst", inst, m_inst);
  endtask

  task automatic update_model();
    logic [31:0] t;
    cyc++;
    if (m_halt) begin
      // absorbing
    end else if (!m_pend && !m_have) begin
      if (imem_gnt) begin
        m_pend = 1'b1;
        m_dly  = $urandom_range(k_dly_max, 0);
      end
    end else if (m_pend) begin
      if (imem_rvalid) begin
        m_inst = imem_rdata;
        m_pend = 1'b0;
        m_have = 1'b1;
      end else if (m_dly > 0) begin
        m_dly--;
      end
    end else if (inst_ready) begin
      if (jalr)                    t = (rs1Data + imm32) & ~32'h1;
      else if (jal || branchTaken) t = m_pc + imm32;
      else                         t = m_pc + 32'd4;
      handoffs++;
      ho_gap  = cyc - last_ho;
      last_ho = cyc;
      m_have  = 1'b0;
      if (t[1]) m_halt = 1'b1;
      else      m_pc   = t;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    update_model();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_cycle();
    imem_gnt = (!m_halt && !m_pend && !m_have) && ($urandom_range(99) < k_gnt_pct);
    imem_rdata = $urandom;
    if (m_pend && m_dly == 0) imem_rvalid = 1'b1;
    else if (!m_pend && k_spur) imem_rvalid = ($urandom_range(3) == 0);
    else imem_rvalid = 1'b0;
    inst_ready = ($urandom_range(99) < k_ready_pct);
    if (k_redir) begin
      branchTaken = ($urandom_range(3) == 0);
      jal         = ($urandom_range(3) == 0);
      jalr        = ($urandom_range(3) == 0);
      imm32 = $urandom_range(1) ? ($urandom & 32'hFFFF_FFFC)
                                : (32'($urandom_range(63)) * 4 - 32'd128);
      if (k_mis && $urandom_range(9) == 0) imm32[1] = 1'b1;
      rs1Data = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1));
    end
    tick();
  endtask

  task automatic set_redir(input bit b, input bit j, input bit jr, input logic [31:0] im,
                           input logic [31:0] r1);
    branchTaken = b;
    jal         = j;
    jalr        = jr;
    imm32       = im;
    rs1Data     = r1;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    inst_ready  = 1'b0;
    #1;
    check_eq("rst_pc", pc, RstPc);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_halt", 32'(halt), 32'd0);
    check_eq("rst_inst", inst, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_hold", 32'(imem_req), 32'd0);
    m_pc = RstPc; m_inst = 32'h0; m_halt = 0; m_pend = 0; m_have = 0;
    last_ho = cyc;
    rst = 1'b1;
    #1;
    check_eq("rel_req", 32'(imem_req), 32'd1);
    check_eq("rel_addr", imem_addr, RstPc);
  endtask

  task automatic run_handoff(input string tag);
    int h0;
    bit done;
    h0   = handoffs;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      rand_cycle();
      if (handoffs != h0) done = 1'b1;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addrs[3];
    logic [31:0] w;
    int          n_addr, h0, nreq;

    rst = 1'b0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; inst_ready = 0;
    set_redir(0, 0, 0, 32'h0, 32'h0);
    cyc = 0; handoffs = 0; last_ho = 0; ho_gap = 0;
    @(negedge clk);
    do_reset();

    // Sequential fetch with single-cycle memory and no backpressure.
    k_gnt_pct = 100; k_dly_max = 0; k_ready_pct = 100; k_redir = 0; k_spur = 0; k_mis = 0;
    n_addr = 0;
    for (int i = 0; i < 9; i++) begin
      if (imem_req && n_addr < 3) begin
        addrs[n_addr] = imem_addr;
        n_addr++;
      end
      h0 = handoffs;
      rand_cycle();
      if (handoffs != h0) check_eq("seq_gap", 32'(ho_gap), 32'd3);
    end
    check_eq("seq_nreq", 32'(n_addr), 32'd3);
    for (int i = 0; i < 3; i++) check_eq("seq_addr", addrs[i], 32'(i * 4));

    // Backpressure plus memory latency.
    do_reset();
    w = 32'hA5A5_1234;
    imem_gnt = 0; tick(); tick();
    imem_gnt = 1; tick(); imem_gnt = 0;
    tick(); tick();
    imem_rvalid = 1; imem_rdata = w; tick(); imem_rvalid = 0; imem_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("bp_inst", inst, w);
    end
    inst_ready = 1; tick(); inst_ready = 0;
    check_eq("bp_pc", pc, 32'h4);
    check_eq("bp_valid_drop", 32'(inst_valid), 32'd0);
    tick();
    check_eq("bp_req_after", 32'(imem_req), 32'd1);

    // Redirects.
    k_gnt_pct = 100; k_dly_max = 1; k_ready_pct = 100; k_spur = 1;
    do_reset();
    set_redir(0, 1, 0, 32'h100, 32'h0);        run_handoff("to_100");
    check_eq("jal_pc", pc, 32'h100);
    set_redir(1, 0, 0, 32'hFFFF_FFF0, 32'h0);  run_handoff("to_f0");
    check_eq("br_pc", pc, 32'hF0);
    set_redir(0, 1, 1, 32'h4, 32'h2001);       run_handoff("to_2004");
    check_eq("jalr_pc", pc, 32'h2004);

    // Misaligned target halts permanently.
    do_reset();
    set_redir(0, 1, 0, 32'h10, 32'h0);         run_handoff("to_10");
    set_redir(0, 1, 0, 32'h6, 32'h0);          run_handoff("mis_ho");
    check_eq("mis_halt", 32'(halt), 32'd1);
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      imem_gnt = 1; imem_rvalid = 1; inst_ready = 1;
      tick();
      if (imem_req || inst_valid || !halt) nreq++;
    end
    check_eq("mis_idle", 32'(nreq), 32'd0);
    check_eq("mis_pc", pc, 32'h10);

    // Wrap-around at the top of the address space.
    do_reset();
    set_redir(0, 0, 1, 32'h0, 32'hFFFF_FFFC);  run_handoff("to_top");
    check_eq("wrap_pc", pc, 32'hFFFF_FFFC);
    check_eq("wrap_plus4", pc_plus4, 32'h0);
    set_redir(0, 0, 0, 32'h0, 32'h0);          run_handoff("wrap_ho");
    check_eq("wrap_addr", imem_addr, 32'h0);
    check_eq("wrap_req", 32'(imem_req), 32'd1);

    // Reset while waiting for data; the late response must be dropped.
    do_reset();
    imem_gnt = 1; tick(); imem_gnt = 0; tick();
    do_reset();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_rvalid = 0;
    check_eq("stale_valid", 32'(inst_valid), 32'd0);
    check_eq("stale_req", 32'(imem_req), 32'd1);
    check_eq("stale_addr", imem_addr, RstPc);
    check_eq("stale_inst", inst, 32'h0);

    // Randomized traffic with occasional resets.
    k_gnt_pct = 60; k_dly_max = 3; k_ready_pct = 60; k_redir = 1; k_spur = 1; k_mis = 1;
    for (int i = 0; i < 3000; i++) begin
      if (m_halt && $urandom_range(7) == 0) do_reset();
      else if ($urandom_range(199) == 0) do_reset();
      else rand_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_req  output  1  instruction-memory request valid.
REQ-005 SHALL have port imem_addr  output  32  request address; equals pc.
REQ-006 SHALL have port imem_gnt  input  1  memory accepts request this cycle.
REQ-007 SHALL have port imem_rvalid  input  1  response data valid.
REQ-008 SHALL have port imem_rdata  input  32  response instruction word.
REQ-009 SHALL have port inst  output  32  held instruction to the decode stage.
REQ-010 SHALL have port inst_valid  output  1  inst is valid this cycle.
REQ-011 SHALL have port inst_ready  input  1  downstream consumes inst this cycle.
REQ-012 SHALL have port pc  output  32  address of the current fetch/instruction.
REQ-013 SHALL have port pc_plus4  output  32  pc+4 modulo 2^32, for jal/jalr link.
REQ-014 SHALL have port branchTaken, jal, jalr  input  1 each  redirect controls, sampled only at handoff.
REQ-015 SHALL have port imm32  input  32  sign-extended immediate from decode.
REQ-016 SHALL have port rs1Data  input  32  rs1 value from decode, for jalr.
REQ-017 SHALL have port halt  output  1  fetch stopped on misaligned target.

Function
REQ-018 SHALL implement FSM states S_REQ, S_WAIT, S_OUT, S_HALT.
REQ-019 SHALL, in S_REQ, drive imem_req=1 and imem_addr=pc; imem_gnt=1 -> S_WAIT next cycle; otherwise hold request and address unchanged.
REQ-020 SHALL, in S_WAIT, drive imem_req=0; imem_rvalid=1 -> capture imem_rdata into inst and go to S_OUT; otherwise remain.
REQ-021 SHALL ignore imem_rvalid in every state except S_WAIT.
REQ-022 SHALL assert inst_valid=1 only in S_OUT; inst stays stable while inst_valid=1 and inst_ready=0.
REQ-023 SHALL, in S_OUT with inst_ready=1 (handoff), load pc with next_pc and go to S_REQ; minimum fetch-to-fetch interval is 3 cycles (S_REQ, S_WAIT, S_OUT) with 1-cycle memory.
REQ-024 SHALL compute next_pc by priority: jalr -> (rs1Data+imm32) with bit0 cleared; else jal or branchTaken -> pc+imm32; else pc+4; all sums modulo 2^32.
REQ-025 SHALL ignore branchTaken/jal/jalr/imm32/rs1Data outside the handoff cycle.
REQ-026 SHALL, if next_pc[1] is 1 at handoff, leave pc unchanged, enter S_HALT, and set halt=1.
REQ-027 SHALL keep S_HALT absorbing until reset: imem_req=0, inst_valid=0, halt=1.
REQ-028 SHALL drive pc_plus4 combinationally as pc+4; at pc=32'hFFFF_FFFC it is 32'h0000_0000.
REQ-029 SHALL have no combinational path from imem_rvalid or imem_rdata to any output.

Reset
REQ-030 SHALL, while rst=0, force state=S_REQ, pc=RESET_PC, inst=32'h0, halt=0, inst_valid=0, and imem_req=0.
REQ-031 SHALL assert imem_req=1 on the first cycle after rst deasserts.
REQ-032 SHALL abandon any outstanding request on reset mid-operation; the late imem_rvalid is discarded per REQ-021.

Verification
REQ-033 Sequential fetch: 1-cycle memory, inst_ready=1, no redirects -> imem_addr sequence 0x0, 0x4, 0x8; inst_valid pulses every 3rd cycle.
REQ-034 Backpressure plus memory latency: imem_gnt delayed 2 cycles, rvalid 3 cycles after gnt, inst_ready low 4 cycles -> inst stable throughout; exactly one handoff; pc then 0x4.
REQ-035 Redirects: pc=0x100; branchTaken, imm32=0xFFFFFFF0 -> pc 0xF0; jal plus jalr with rs1Data=0x2001, imm32=0x4 -> pc 0x2004 (jalr wins, bit0 cleared).
REQ-036 Misalignment: pc=0x10, jal with imm32=0x6 -> halt=1, pc stays 0x10, imem_req stays 0 for 20 cycles.
REQ-037 Wrap-around: RESET_PC=32'hFFFF_FFFC, no redirect -> pc_plus4=0x0 and next imem_addr=0x0.
REQ-038 Reset mid-WAIT: rst low while in S_WAIT, stale rvalid after release -> inst_valid=0, imem_req=1 at RESET_PC; data from the stale rvalid never appears on inst.
